// File: rtl/prim_fifo_arb_ctrl.sv
// Shared-FIFO write arbiter and sequencer.
// Several requesters share one synchronous FIFO through a round-robin grant.
// The block adds a drain/discard flush sequencer and a registered fill-level
// watermark. Pointer, full/empty and depth bookkeeping lives in prim_fifo_sync_cnt.

// Pointer and occupancy counter for a Depth-entry FIFO.
module prim_fifo_sync_cnt #(
    parameter int Depth  = 4,
    parameter bit Secure = 1'b0,
    localparam int PtrW   = $clog2(Depth),
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              incr_wptr_i,
    input  logic              incr_rptr_i,
    output logic [PtrW-1:0]   wptr_o,
    output logic [PtrW-1:0]   rptr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [DepthW-1:0] depth_o,
    output logic              err_o
);
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [DepthW-1:0] depth_q;
    logic              dup_err;

    // Pointers wrap at Depth-1; occupancy tracks pushes minus pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            depth_q <= '0;
        end else begin
            if (incr_wptr_i) wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            if (incr_rptr_i) rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            depth_q <= depth_q + DepthW'(incr_wptr_i) - DepthW'(incr_rptr_i);
        end
    end

    if (Secure) begin : g_dup
        logic [DepthW-1:0] depth_dup_q;

        // Redundant occupancy copy; any divergence flags a fault.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)    depth_dup_q <= '0;
            else if (clr_i) depth_dup_q <= '0;
            else            depth_dup_q <= depth_dup_q + DepthW'(incr_wptr_i) - DepthW'(incr_rptr_i);
        end

        assign dup_err = (depth_dup_q != depth_q);
    end else begin : g_nodup
        assign dup_err = 1'b0;
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign depth_o = depth_q;
    assign full_o  = (depth_q == DepthW'(Depth));
    assign empty_o = (depth_q == '0);
    assign err_o   = (depth_q > DepthW'(Depth)) | dup_err;
endmodule

module prim_fifo_arb_ctrl #(
    parameter int NumReq = 4,
    parameter int Depth  = 4,
    parameter int Width  = 8,
    parameter bit Secure = 1'b0,
    localparam int IdxW   = $clog2(NumReq),
    localparam int DepthW = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*Width-1:0] data_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [Width-1:0]        rdata_o,
    output logic [IdxW-1:0]         rsrc_o,
    input  logic                    flush_i,
    input  logic                    flush_discard_i,
    output logic                    flush_busy_o,
    output logic                    flush_done_o,
    input  logic [DepthW-1:0]       wmark_i,
    output logic                    wmark_o,
    output logic [DepthW-1:0]       depth_o,
    output logic                    err_o
);
    localparam int PtrW = $clog2(Depth);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StClear = 2'd2
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   rr_q, gnt_idx, rr_nxt;
    logic [IdxW:0]     cand;
    logic              gnt_any, gnt_en, pop, clr;
    logic              full, empty, cnt_err, onehot_err;
    logic [PtrW-1:0]   wptr, rptr;
    logic [DepthW-1:0] cnt_depth;
    logic              flush_done_q, wmark_q;

    logic [Width-1:0]  mem_data [Depth];
    logic [IdxW-1:0]   mem_src  [Depth];

    prim_fifo_sync_cnt #(
        .Depth  (Depth),
        .Secure (Secure)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr),
        .incr_wptr_i (gnt_any),
        .incr_rptr_i (pop),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .full_o      (full),
        .empty_o     (empty),
        .depth_o     (cnt_depth),
        .err_o       (cnt_err)
    );

    assign gnt_en = (state_q == StIdle) && !full;
    assign clr    = (state_q == StClear);

    // Round-robin search starting at rr_q; first asserted request wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt_o   = '0;
        if (gnt_en) begin
            for (int i = 0; i < NumReq; i++) begin
                // NOTE: blocking assignments here model combinational evaluation order; clocked state below uses non-blocking.
                cand = {1'b0, rr_q} + (IdxW + 1)'(i);
                if (cand >= (IdxW + 1)'(NumReq)) cand = cand - (IdxW + 1)'(NumReq);
                if (!gnt_any && req_i[cand[IdxW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[IdxW-1:0];
                end
            end
        end
        if (gnt_any) gnt_o[gnt_idx] = 1'b1;
    end

    assign rr_nxt = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);

    // Write the granted requester's data and index at the write pointer.
    // NOTE: the storage array is deliberately not reset; its contents are only read when the counter says the entry is valid.
    always_ff @(posedge clk_i) begin
        if (gnt_any) begin
            mem_data[wptr] <= data_i[gnt_idx*Width +: Width];
            mem_src[wptr]  <= gnt_idx;
        end
    end

    // Flush sequencer: Idle -> Drain (pop until empty) or straight to Clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= (state_q == StClear);
            case (state_q)
                StIdle:  if (flush_i) state_q <= flush_discard_i ? StClear : StDrain;
                StDrain: if (empty) state_q <= StClear;
                StClear: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Round-robin pointer advances past each winner and restarts on a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      rr_q <= '0;
        else if (clr)     rr_q <= '0;
        else if (gnt_any) rr_q <= rr_nxt;
    end

    // Watermark flag registered one cycle behind the occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wmark_q <= 1'b0;
        else         wmark_q <= (cnt_depth >= wmark_i);
    end

    assign rvalid_o     = !empty && (state_q != StClear);
    assign pop          = rvalid_o && rready_i;
    assign rdata_o      = rvalid_o ? mem_data[rptr] : '0;
    assign rsrc_o       = rvalid_o ? mem_src[rptr] : '0;
    assign flush_busy_o = (state_q == StDrain) || (state_q == StClear);
    assign flush_done_o = flush_done_q;
    assign wmark_o      = wmark_q;
    assign depth_o      = cnt_depth;
    assign onehot_err   = Secure && gnt_any && |(gnt_o & (gnt_o - NumReq'(1)));
    assign err_o        = cnt_err | onehot_err;
endmodule
